frog_ctrl: RTL and testbench

- Game-flow controller that sequences the frogdis position block.
- Turns raw direction key levels into single-cycle, mutually exclusive move pulses (l/d/u/r), with fixed priority and auto-repeat on hold.
- Runs the round state machine (idle, play, dead, win, game over) and pulses frog_rst to return the frog to its start square.
- Sits between board input synchronizers and frogdis; lane/collision logic supplies hit.

---
 rtl/frog_pkg.sv | 32 +++
 rtl/frog_key_repeat.sv | 92 +++++++++
 rtl/frog_ctrl.sv | 149 ++++++++++++++
 tb/tb_frog_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared types for the frog game-flow controller: round states, move
// directions and the board coordinate width.
package frog_pkg;

  localparam int POS_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    DEAD = 3'd2,
    WIN  = 3'd3,
    OVER = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_U    = 3'd1,
    DIR_D    = 3'd2,
    DIR_L    = 3'd3,
    DIR_R    = 3'd4
  } dir_e;

  // Press vector is packed {u, d, l, r}; up beats down beats left beats right.
  function automatic dir_e prio_dir(input logic [3:0] press);
    if (press[3]) return DIR_U;
    if (press[2]) return DIR_D;
    if (press[1]) return DIR_L;
    if (press[0]) return DIR_R;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/frog_key_repeat.sv
// Key edge detection, fixed-priority press select and hold/auto-repeat timing.
// o_dir is a combinational one-cycle direction strobe; the caller registers it.
module frog_key_repeat
  import frog_pkg::*;
#(
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_tick,
  input  logic i_key_l,
  input  logic i_key_d,
  input  logic i_key_u,
  input  logic i_key_r,
  output dir_e o_dir,
  output logic o_press
);

  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [3:0]    w_keys;
  logic [3:0]    w_press;
  logic [3:0]    r_key_prev;
  dir_e          w_win;
  dir_e          r_held_dir;
  logic          r_repeating;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_held_key;
  logic          w_fire;

  assign w_keys  = {i_key_u, i_key_d, i_key_l, i_key_r};
  assign w_press = w_keys & ~r_key_prev;
  assign o_press = |w_press;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_held_key = 1'b0;
    case (r_held_dir)
      DIR_U:   w_held_key = i_key_u;
      DIR_D:   w_held_key = i_key_d;
      DIR_L:   w_held_key = i_key_l;
      DIR_R:   w_held_key = i_key_r;
      default: w_held_key = 1'b0;
    endcase
  end

  always_comb begin
    w_win     = prio_dir(w_press);
    w_cnt_inc = r_cnt + 1'b1;
    w_fire    = 1'b0;
    if (r_held_dir != DIR_NONE && w_held_key && i_tick)
      w_fire = (w_cnt_inc == (r_repeating ? CW'(REPEAT_TICKS) : CW'(HOLD_TICKS)));
    if (w_win != DIR_NONE)
      o_dir = w_win;
    else if (w_fire)
      o_dir = r_held_dir;
    else
      o_dir = DIR_NONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_key_prev  <= '0;
      r_held_dir  <= DIR_NONE;
      r_repeating <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_key_prev <= w_keys;
      if (w_win != DIR_NONE) begin
        r_held_dir  <= w_win;
        r_repeating <= 1'b0;
        r_cnt       <= '0;
      end else if (r_held_dir != DIR_NONE && !w_held_key) begin
        r_held_dir  <= DIR_NONE;
        r_repeating <= 1'b0;
        r_cnt       <= '0;
      end else if (r_held_dir != DIR_NONE && i_tick) begin
        if (w_fire) begin
          r_repeating <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/frog_ctrl.sv
// Frog game-flow controller: registered move pulses, round state machine,
// lives and score. Define FROG_CTRL_SCORE_EN to build the score counter.
module frog_ctrl
  import frog_pkg::*;
#(
  parameter int GOAL_ROW     = 0,
  parameter int LIVES        = 3,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 4,
  parameter int DEAD_TICKS   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             key_l,
  input  logic             key_d,
  input  logic             key_u,
  input  logic             key_r,
  input  logic             hit,
  input  logic [POS_W-1:0] frog_row,
  output logic             l,
  output logic             d,
  output logic             u,
  output logic             r,
  output logic             frog_rst,
  output logic [1:0]       lives,
  output logic [2:0]       state,
  output logic [7:0]       score
);

  localparam int DW = $clog2(DEAD_TICKS + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  dir_e          w_dir;
  logic          w_press;
  logic [DW-1:0] r_dead_cnt;
  logic          w_dead_done;
  logic [1:0]    r_lives;
  logic          r_frog_rst;
  logic          r_l, r_d, r_u, r_r;
  logic          w_frog_rst_nxt;
  logic          w_move_ok;
  logic          w_l_nxt, w_d_nxt, w_u_nxt, w_r_nxt;

  frog_key_repeat #(
    .HOLD_TICKS   (HOLD_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) u_keys (
    .clock   (clock),
    .reset   (reset),
    .i_tick  (tick),
    .i_key_l (key_l),
    .i_key_d (key_d),
    .i_key_u (key_u),
    .i_key_r (key_r),
    .o_dir   (w_dir),
    .o_press (w_press)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_dead_done = tick && ((r_dead_cnt + 1'b1) == DW'(DEAD_TICKS));

  // The goal check is skipped while frog_rst is out: frog_row still shows the
  // pre-respawn position until frogdis acts on the pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_press) w_state_nxt = PLAY;
      PLAY: begin
        if (hit)
          w_state_nxt = DEAD;
        else if (frog_row == POS_W'(GOAL_ROW) && !r_frog_rst)
          w_state_nxt = WIN;
      end
      DEAD: if (w_dead_done) w_state_nxt = (r_lives == 2'd0) ? OVER : PLAY;
      WIN:  w_state_nxt = PLAY;
      OVER: if (w_press) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Moves only survive a cycle that stays in PLAY, so they can never meet frog_rst.
  always_comb begin
    w_frog_rst_nxt = (r_state != PLAY) && (w_state_nxt == PLAY);
    w_move_ok      = (r_state == PLAY) && (w_state_nxt == PLAY);
    w_l_nxt        = w_move_ok && (w_dir == DIR_L);
    w_d_nxt        = w_move_ok && (w_dir == DIR_D);
    w_u_nxt        = w_move_ok && (w_dir == DIR_U);
    w_r_nxt        = w_move_ok && (w_dir == DIR_R);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frog_rst <= 1'b0;
      r_l        <= 1'b0;
      r_d        <= 1'b0;
      r_u        <= 1'b0;
      r_r        <= 1'b0;
      r_lives    <= 2'(LIVES);
      r_dead_cnt <= '0;
    end else begin
      r_frog_rst <= w_frog_rst_nxt;
      r_l        <= w_l_nxt;
      r_d        <= w_d_nxt;
      r_u        <= w_u_nxt;
      r_r        <= w_r_nxt;
      if (r_state == PLAY && w_state_nxt == DEAD) begin
        if (r_lives != 2'd0) r_lives <= r_lives - 2'd1;
      end else if ((r_state == OVER || r_state == IDLE) && w_state_nxt != r_state) begin
        r_lives <= 2'(LIVES);
      end
      if (r_state != DEAD)
        r_dead_cnt <= '0;
      else if (tick)
        r_dead_cnt <= r_dead_cnt + 1'b1;
    end
  end

`ifdef FROG_CTRL_SCORE_EN
  logic [7:0] r_score;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_score <= 8'd0;
    else if (r_state == IDLE && w_state_nxt == PLAY)
      r_score <= 8'd0;
    else if (r_state == WIN)
      r_score <= r_score + 8'd1;
  end

  assign score = r_score;
`else
  assign score = 8'd0;
`endif

  assign l        = r_l;
  assign d        = r_d;
  assign u        = r_u;
  assign r        = r_r;
  assign frog_rst = r_frog_rst;
  assign lives    = r_lives;
  assign state    = r_state;

endmodule

// File: tb/tb_frog_ctrl.sv
// Directed bench for frog_ctrl: key pulses, auto-repeat, win/death/game-over
// flow and asynchronous reset. Score expectations follow FROG_CTRL_SCORE_EN.
module tb_frog_ctrl;
  import frog_pkg::*;

`ifdef FROG_CTRL_SCORE_EN
  localparam logic [7:0] SCORE_AFTER_WIN = 8'd1;
`else
  localparam logic [7:0] SCORE_AFTER_WIN = 8'd0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b1;
  logic       key_l = 1'b0, key_d = 1'b0, key_u = 1'b0, key_r = 1'b0;
  logic       hit   = 1'b0;
  logic [3:0] frog_row = 4'd7;
  logic       l, d, u, r, frog_rst;
  logic [1:0] lives;
  logic [2:0] state;
  logic [7:0] score;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  frog_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .key_l    (key_l),
    .key_d    (key_d),
    .key_u    (key_u),
    .key_r    (key_r),
    .hit      (hit),
    .frog_row (frog_row),
    .l        (l),
    .d        (d),
    .u        (u),
    .r        (r),
    .frog_rst (frog_rst),
    .lives    (lives),
    .state    (state),
    .score    (score)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_score", 32'(score), 32'd0);
    check("rst_moves", 32'({l, d, u, r}), 32'h0);
    check("rst_frog_rst", 32'(frog_rst), 32'd0);
    reset = 1'b1;
    step();

    // IDLE press starts the round with frog_rst and no move
    key_u = 1'b1;
    step();
    check("start_frog_rst", 32'(frog_rst), 32'd1);
    check("start_state", 32'(state), 32'(PLAY));
    check("start_no_move", 32'({l, d, u, r}), 32'h0);
    key_u = 1'b0;
    step();
    check("start_rst_done", 32'(frog_rst), 32'd0);

    // u press: pulse exactly one cycle after the sampling edge
    key_u = 1'b1;
    step();
    check("u_pulse", 32'({l, d, u, r}), 32'b0010);
    key_u = 1'b0;
    step();
    check("u_pulse_end", 32'({l, d, u, r}), 32'h0);

    // u, d, l together: u wins
    key_u = 1'b1; key_d = 1'b1; key_l = 1'b1;
    step();
    check("prio_udl", 32'({l, d, u, r}), 32'b0010);
    key_u = 1'b0; key_d = 1'b0; key_l = 1'b0;
    step();

    // l and r together: only l; hold l for auto-repeat at +8 then +4 ticks
    key_l = 1'b1; key_r = 1'b1;
    step();
    check("prio_lr", 32'({l, d, u, r}), 32'b1000);
    key_r = 1'b0;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      pulses += int'(l);
    end
    check("hold_quiet", 32'(pulses), 32'd0);
    step();
    check("hold_first_rep", 32'({l, d, u, r}), 32'b1000);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(l);
    end
    check("rep_quiet", 32'(pulses), 32'd0);
    step();
    check("rep_second", 32'({l, d, u, r}), 32'b1000);
    key_l = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      pulses += int'(l);
    end
    check("release_no_rep", 32'(pulses), 32'd0);

    // tick held low: edge moves still happen, auto-repeat frozen
    tick  = 1'b0;
    key_d = 1'b1;
    step();
    check("d_no_tick", 32'({l, d, u, r}), 32'b0100);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += int'(d);
    end
    check("freeze_rep", 32'(pulses), 32'd0);
    key_d = 1'b0;
    tick  = 1'b1;
    step();

    // Goal reached: one WIN cycle, then score, frog_rst and PLAY
    frog_row = 4'd0;
    step();
    check("win_state", 32'(state), 32'(WIN));
    check("win_no_rst", 32'(frog_rst), 32'd0);
    frog_row = 4'd7;
    step();
    check("win_back_play", 32'(state), 32'(PLAY));
    check("win_frog_rst", 32'(frog_rst), 32'd1);
    check("win_score", 32'(score), 32'(SCORE_AFTER_WIN));
    step();
    check("win_rst_done", 32'(frog_rst), 32'd0);

    // hit and goal together: hit wins; hit held through DEAD; presses dropped
    hit = 1'b1; frog_row = 4'd0;
    step();
    check("hit_state", 32'(state), 32'(DEAD));
    check("hit_lives", 32'(lives), 32'd2);
    check("hit_score", 32'(score), 32'(SCORE_AFTER_WIN));
    frog_row = 4'd7;
    key_r = 1'b1;
    step();
    check("dead_no_move", 32'({l, d, u, r}), 32'h0);
    key_r = 1'b0;
    step(14);
    check("dead_hold", 32'(state), 32'(DEAD));
    check("dead_lives_hold", 32'(lives), 32'd2);
    hit = 1'b0;
    step();
    check("respawn_state", 32'(state), 32'(PLAY));
    check("respawn_frog_rst", 32'(frog_rst), 32'd1);

    // Two more deaths: lives 1 then 0, ending in OVER
    hit = 1'b1;
    step();
    check("hit2_lives", 32'(lives), 32'd1);
    hit = 1'b0;
    step(15);
    step();
    check("respawn2", 32'(state), 32'(PLAY));
    hit = 1'b1;
    step();
    check("hit3_lives", 32'(lives), 32'd0);
    hit = 1'b0;
    step(15);
    check("dead3_hold", 32'(state), 32'(DEAD));
    step();
    check("over_state", 32'(state), 32'(OVER));
    check("over_no_rst", 32'(frog_rst), 32'd0);

    // Press in OVER: back to IDLE, lives reloaded, score kept
    key_l = 1'b1;
    step();
    check("over_idle", 32'(state), 32'(IDLE));
    check("over_lives", 32'(lives), 32'd3);
    check("over_score_kept", 32'(score), 32'(SCORE_AFTER_WIN));
    check("over_no_move", 32'({l, d, u, r}), 32'h0);
    key_l = 1'b0;
    step();

    // New game clears score; die, then reset mid-DEAD
    key_u = 1'b1;
    step();
    check("game2_state", 32'(state), 32'(PLAY));
    check("game2_score", 32'(score), 32'd0);
    key_u = 1'b0;
    step();
    hit = 1'b1;
    step();
    check("game2_dead", 32'(state), 32'(DEAD));
    hit = 1'b0;
    step(5);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'(IDLE));
    check("mid_rst_lives", 32'(lives), 32'd3);
    check("mid_rst_frog_rst", 32'(frog_rst), 32'd0);
    check("mid_rst_moves", 32'({l, d, u, r}), 32'h0);
    reset = 1'b1;
    step(2);
    check("post_rst_state", 32'(state), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
